sha256_block_ctrl: RTL

//  Sequencer for the SHA-256 compression datapath. It accepts one short message per

---
 rtl/sha256_pkg.sv | 52 +++++
 rtl/sha256_msg_sched.sv | 50 +++++
 rtl/sha256_block_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and sigma helpers
// for the block sequencer and its message schedule.
package sha256_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ROUND,
    FINAL,
    DONE
  } state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  function automatic logic [31:0] ror32(
    input logic [31:0] x,
    input int unsigned n
  );
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror32(x, 7) ^ ror32(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror32(x, 17) ^ ror32(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_msg_sched.sv
// 16-word sliding message schedule window: loads the padded
// block on accept and rolls one W_t per round.
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int MSG_W = 96
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [MSG_W-1:0] message,
  output logic [31:0]      w_t
);

  localparam int NW = MSG_W / 32;

  logic [31:0] win [16];
  logic [31:0] ld  [16];
  logic [31:0] nxt;

  // Single-block padding: message words, 0x80 marker, zeros, bit length.
  for (genvar i = 0; i < 16; i++) begin : g_ld
    if (i < NW) begin : g_msg
      assign ld[i] = message[MSG_W-1-32*i -: 32];
    end else if (i == NW) begin : g_pad
      assign ld[i] = 32'h8000_0000;
    end else if (i == 15) begin : g_len
      assign ld[i] = 32'(MSG_W);
    end else begin : g_zero
      assign ld[i] = '0;
    end
  end

  assign nxt = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= ld[i];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= nxt;
    end
  end

  assign w_t = win[0];

endmodule

// File: rtl/sha256_block_ctrl.sv
// SHA-256 single-block sequencer: FSM, round counter, K lookup
// and core strobes around the message schedule window.
module sha256_block_ctrl
  import sha256_pkg::*;
#(
  parameter int MSG_W = 96
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [MSG_W-1:0] message,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic             core_init,
  output logic             core_round_en,
  output logic             core_final,
  output logic [5:0]       round_idx,
  output logic [31:0]      w_t,
  output logic [31:0]      k_t
);

  state_t state;
  logic   accept;

  assign accept = start && ready;

  sha256_msg_sched #(
    .MSG_W(MSG_W)
  ) u_sched (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .shift   (state == ROUND),
    .message (message),
    .w_t     (w_t)
  );

  assign k_t = K[round_idx];

  // Strobes are registered from the next state so each is high
  // for exactly the cycles spent in its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      round_idx     <= '0;
      ready         <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      core_init     <= 1'b0;
      core_round_en <= 1'b0;
      core_final    <= 1'b0;
    end else begin
      done          <= 1'b0;
      core_init     <= 1'b0;
      core_round_en <= 1'b0;
      core_final    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            state     <= LOAD;
            ready     <= 1'b0;
            busy      <= 1'b1;
            core_init <= 1'b1;
          end
        end
        LOAD: begin
          round_idx <= '0;
          if (abort) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else begin
            state         <= ROUND;
            core_round_en <= 1'b1;
          end
        end
        ROUND: begin
          if (abort) begin
            state <= IDLE;
            ready <= 1'b1;
            busy  <= 1'b0;
          end else if (round_idx == 6'd63) begin
            state      <= FINAL;
            core_final <= 1'b1;
          end else begin
            round_idx     <= round_idx + 6'd1;
            core_round_en <= 1'b1;
          end
        end
        FINAL: begin
          state <= abort ? IDLE : DONE;
          ready <= abort;
          busy  <= 1'b0;
          done  <= !abort;
        end
        DONE: begin
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
